// File: rtl/irrigacao_multizona.sv
// irrigacao_multizona: one water tank feeding N_ZONAS irrigation zones.
// Zones are served round-robin with timed sprinkler (aspersao) or drip
// (gotejamento) irrigation. The tank is cleaned periodically, and the
// fill timeout, the external error and sensor inconsistency all lead to ERRO.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   l_i, m_i, h_i         tank level sensors (low / mid / high mark reached)
//   req_i   [N_ZONAS]     zone requests, OR-latched into the pending set
//   modo_i  [N_ZONAS]     per-zone mode: 1 = aspersao, 0 = gotejamento
//   agro_i                agrochemical request (used only with IRRIGACAO_AGRO_EN)
//   e_i                   external error
//   s_enchendo_o          inlet valve open
//   s_cheio_o             tank full, idle
//   s_aspersao_o          sprinkler pump on
//   s_gotejamento_o       drip valve open
//   s_agro_o              agrochemical injector on
//   s_limpeza_o           cleaning pump on
//   s_saida_limpeza_o     drain valve open
//   s_erro_o              error indicator
//   zona_ativa_o [N_ZONAS] one-hot active zone, 0 outside IRRIGANDO
//   fim_zona_o            1-cycle pulse on normal zone completion
//
// Build option: define IRRIGACAO_AGRO_EN to enable agrochemical injection on
// sprinkler zones. With the macro undefined, s_agro_o is constant 0.
module irrigacao_multizona #(
    parameter int unsigned N_ZONAS        = 4,
    parameter int unsigned TIMER_W        = 8,
    parameter int unsigned T_ASPERSAO     = 20,
    parameter int unsigned T_GOTEJAMENTO  = 40,
    parameter int unsigned T_LIMPEZA      = 10,
    parameter int unsigned T_ENCHE_MAX    = 100,
    parameter int unsigned CICLOS_LIMPEZA = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               l_i,
    input  logic               m_i,
    input  logic               h_i,
    input  logic [N_ZONAS-1:0] req_i,
    input  logic [N_ZONAS-1:0] modo_i,
    input  logic               agro_i,
    input  logic               e_i,
    output logic               s_enchendo_o,
    output logic               s_cheio_o,
    output logic               s_aspersao_o,
    output logic               s_gotejamento_o,
    output logic               s_agro_o,
    output logic               s_limpeza_o,
    output logic               s_saida_limpeza_o,
    output logic               s_erro_o,
    output logic [N_ZONAS-1:0] zona_ativa_o,
    output logic               fim_zona_o
);

    localparam int unsigned ZW = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1;
    localparam int unsigned FW = $clog2(T_ENCHE_MAX + 1);
    localparam int unsigned CW = $clog2(CICLOS_LIMPEZA + 1);

    typedef enum logic [2:0] {
        ENCHENDO  = 3'd0,
        CHEIO     = 3'd1,
        IRRIGANDO = 3'd2,
        LIMPEZA   = 3'd3,
        ERRO      = 3'd4
    } estado_t;

    estado_t           state_q, state_d;
    logic [N_ZONAS-1:0] pend_q, pend_d;
    logic [ZW-1:0]     ptr_q, ptr_d;
    logic [ZW-1:0]     zona_q, zona_d;
    logic              modo_q, modo_d;
    logic [TIMER_W-1:0] tempo_q, tempo_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [CW-1:0]     cont_q, cont_d;
    logic              fim_q, fim_d;

    logic              falha;
    logic              achou;
    logic [ZW-1:0]     sel_zona;

`ifdef IRRIGACAO_AGRO_EN
    logic agro_q, agro_d;
`else
    logic unused_agro;
    assign unused_agro = agro_i;
`endif

    // Level sensors must be monotonic: a higher mark without the lower one is a fault.
    assign falha = (h_i & ~m_i) | (m_i & ~l_i);

    // Round-robin pick: first pending zone at or after the pointer, wrapping.
    always_comb begin : pick
        int unsigned idx;
        idx      = 0;
        achou    = 1'b0;
        sel_zona = ptr_q;
        for (int unsigned i = 0; i < N_ZONAS; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_ZONAS) begin
                idx = idx - N_ZONAS;
            end
            if (!achou && pend_q[ZW'(idx)]) begin
                achou    = 1'b1;
                sel_zona = ZW'(idx);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ENCHENDO;
            pend_q  <= '0;
            ptr_q   <= '0;
            zona_q  <= '0;
            modo_q  <= 1'b0;
            tempo_q <= '0;
            fill_q  <= '0;
            cont_q  <= '0;
            fim_q   <= 1'b0;
`ifdef IRRIGACAO_AGRO_EN
            agro_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            zona_q  <= zona_d;
            modo_q  <= modo_d;
            tempo_q <= tempo_d;
            fill_q  <= fill_d;
            cont_q  <= cont_d;
            fim_q   <= fim_d;
`ifdef IRRIGACAO_AGRO_EN
            agro_q  <= agro_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | req_i;
        ptr_d   = ptr_q;
        zona_d  = zona_q;
        modo_d  = modo_q;
        tempo_d = tempo_q;
        fill_d  = '0;
        cont_d  = cont_q;
        fim_d   = 1'b0;
`ifdef IRRIGACAO_AGRO_EN
        agro_d  = agro_q;
`endif

        if (e_i || falha) begin
            state_d = ERRO;
            tempo_d = '0;
        end else begin
            unique case (state_q)
                ENCHENDO: begin
                    if (h_i) begin
                        state_d = CHEIO;
                    end else if (fill_q == FW'(T_ENCHE_MAX - 1)) begin
                        state_d = ERRO;
                    end else begin
                        fill_d = fill_q + FW'(1);
                    end
                end
                CHEIO: begin
                    if (!l_i) begin
                        state_d = ENCHENDO;
                    end else if (achou) begin
                        state_d = IRRIGANDO;
                        zona_d  = sel_zona;
                        modo_d  = modo_i[sel_zona];
                        tempo_d = modo_i[sel_zona] ? TIMER_W'(T_ASPERSAO - 1)
                                                   : TIMER_W'(T_GOTEJAMENTO - 1);
`ifdef IRRIGACAO_AGRO_EN
                        agro_d  = agro_i & modo_i[sel_zona];
`endif
                    end
                end
                IRRIGANDO: begin
                    if (!l_i) begin
                        // Abort: zone stays pending and will restart with a full time.
                        state_d = ENCHENDO;
                    end else if (tempo_q == '0) begin
                        fim_d  = 1'b1;
                        pend_d = (pend_q & ~(N_ZONAS'(1) << zona_q)) | req_i;
                        ptr_d  = (zona_q == ZW'(N_ZONAS - 1)) ? '0 : zona_q + ZW'(1);
                        if (32'(cont_q) + 32'd1 == CICLOS_LIMPEZA) begin
                            state_d = LIMPEZA;
                            cont_d  = '0;
                            tempo_d = TIMER_W'(T_LIMPEZA - 1);
                        end else begin
                            state_d = CHEIO;
                            cont_d  = cont_q + CW'(1);
                        end
                    end else begin
                        tempo_d = tempo_q - TIMER_W'(1);
                    end
                end
                LIMPEZA: begin
                    if (tempo_q == '0) begin
                        state_d = ENCHENDO;
                    end else begin
                        tempo_d = tempo_q - TIMER_W'(1);
                    end
                end
                ERRO: begin
                    state_d = ENCHENDO;
                    tempo_d = '0;
                end
                default: begin
                    state_d = ENCHENDO;
                end
            endcase
        end
    end

    // Moore output decode from registered state.
    always_comb begin
        s_enchendo_o      = 1'b0;
        s_cheio_o         = 1'b0;
        s_aspersao_o      = 1'b0;
        s_gotejamento_o   = 1'b0;
        s_agro_o          = 1'b0;
        s_limpeza_o       = 1'b0;
        s_saida_limpeza_o = 1'b0;
        s_erro_o          = 1'b0;
        zona_ativa_o      = '0;
        fim_zona_o        = fim_q;
        unique case (state_q)
            ENCHENDO: s_enchendo_o = 1'b1;
            CHEIO:    s_cheio_o    = 1'b1;
            IRRIGANDO: begin
                s_aspersao_o    = modo_q;
                s_gotejamento_o = ~modo_q;
                zona_ativa_o    = N_ZONAS'(1) << zona_q;
`ifdef IRRIGACAO_AGRO_EN
                s_agro_o        = modo_q & agro_q;
`endif
            end
            LIMPEZA: begin
                s_limpeza_o       = 1'b1;
                s_saida_limpeza_o = 1'b1;
            end
            ERRO:    s_erro_o = 1'b1;
            default: s_enchendo_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_irrigacao_multizona.sv
module tb_irrigacao_multizona;

    localparam int N         = 4;
    localparam int T_ASP     = 20;
    localparam int T_GOT     = 40;
    localparam int T_LIMP    = 10;
    localparam int T_FILLMAX = 100;
    localparam int N_CLEAN   = 3;

    localparam int M_FILL = 0;
    localparam int M_FULL = 1;
    localparam int M_IRR  = 2;
    localparam int M_CLN  = 3;
    localparam int M_ERR  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, l, m, h, agro, e;
    logic [N-1:0] req, modo;

    logic         s_enchendo, s_cheio, s_aspersao, s_gotejamento, s_agro;
    logic         s_limpeza, s_saida_limpeza, s_erro, fim_zona;
    logic [N-1:0] zona_ativa;

    irrigacao_multizona #(
        .N_ZONAS(N), .TIMER_W(8), .T_ASPERSAO(T_ASP), .T_GOTEJAMENTO(T_GOT),
        .T_LIMPEZA(T_LIMP), .T_ENCHE_MAX(T_FILLMAX), .CICLOS_LIMPEZA(N_CLEAN)
    ) dut (
        .clk_i(clk), .rst_i(rst), .l_i(l), .m_i(m), .h_i(h),
        .req_i(req), .modo_i(modo), .agro_i(agro), .e_i(e),
        .s_enchendo_o(s_enchendo), .s_cheio_o(s_cheio),
        .s_aspersao_o(s_aspersao), .s_gotejamento_o(s_gotejamento),
        .s_agro_o(s_agro), .s_limpeza_o(s_limpeza),
        .s_saida_limpeza_o(s_saida_limpeza), .s_erro_o(s_erro),
        .zona_ativa_o(zona_ativa), .fim_zona_o(fim_zona)
    );

    // Reference model: mode number, elapsed up-counters and a pending bit set.
    int           st_m;
    bit [N-1:0]   pend_m;
    int           ptr_m, zone_m, elap_m, fill_m, done_m;
    bit           sprink_m, agro_m, fim_m;

    int           checks = 0;
    int           errors = 0;
    int           cycle  = 0;
    logic [12:0]  exp_q[$];
    int           fim_cyc_q[$];

    function automatic logic [12:0] expected();
        logic [N-1:0] za;
        logic         ag;
        za = (st_m == M_IRR) ? (N'(1) << zone_m) : '0;
`ifdef IRRIGACAO_AGRO_EN
        ag = (st_m == M_IRR) && sprink_m && agro_m;
`else
        ag = 1'b0;
`endif
        return {st_m == M_FILL, st_m == M_FULL, st_m == M_IRR && sprink_m,
                st_m == M_IRR && !sprink_m, ag, st_m == M_CLN, st_m == M_CLN,
                st_m == M_ERR, za, fim_m};
    endfunction

    task automatic model_step();
        bit [N-1:0] np;
        bit         flt, found;
        int         k, dur;
        fim_m = 1'b0;
        if (rst) begin
            st_m = M_FILL; pend_m = '0; ptr_m = 0; zone_m = 0; elap_m = 0;
            fill_m = 0; done_m = 0; sprink_m = 0; agro_m = 0;
        end else begin
            np  = pend_m | req;
            flt = (h && !m) || (m && !l);
            if (e || flt) begin
                st_m = M_ERR; elap_m = 0;
            end else begin
                case (st_m)
                    M_FILL: begin
                        if (h) st_m = M_FULL;
                        else begin
                            fill_m++;
                            if (fill_m == T_FILLMAX) st_m = M_ERR;
                        end
                    end
                    M_FULL: begin
                        if (!l) st_m = M_FILL;
                        else if (pend_m != 0) begin
                            found = 0;
                            for (int i = 0; i < N; i++) begin
                                k = (ptr_m + i) % N;
                                if (!found && pend_m[k]) begin found = 1; zone_m = k; end
                            end
                            sprink_m = modo[zone_m];
                            agro_m   = agro;
                            elap_m   = 0;
                            st_m     = M_IRR;
                        end
                    end
                    M_IRR: begin
                        if (!l) st_m = M_FILL;
                        else begin
                            elap_m++;
                            dur = sprink_m ? T_ASP : T_GOT;
                            if (elap_m == dur) begin
                                fim_m      = 1'b1;
                                np[zone_m] = req[zone_m];
                                ptr_m      = (zone_m + 1) % N;
                                done_m++;
                                if (done_m == N_CLEAN) begin
                                    done_m = 0; elap_m = 0; st_m = M_CLN;
                                end else st_m = M_FULL;
                            end
                        end
                    end
                    M_CLN: begin
                        elap_m++;
                        if (elap_m == T_LIMP) st_m = M_FILL;
                    end
                    default: st_m = M_FILL;
                endcase
            end
            pend_m = np;
            if (st_m != M_FILL) fill_m = 0;
        end
        if (fim_m) fim_cyc_q.push_back(cycle);
        exp_q.push_back(expected());
    endtask

    // Inputs set before tick() are sampled at its rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        cycle++;
    endtask

    task automatic set_level(input int lv);
        l = (lv >= 1); m = (lv >= 2); h = (lv >= 3);
    endtask

    // Monitor: compares every presented output cycle and every Fim_Zona pulse.
    int mon_idx = 0;
    initial begin
        logic [12:0] exp_v, act_v;
        int          c;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {s_enchendo, s_cheio, s_aspersao, s_gotejamento, s_agro,
                         s_limpeza, s_saida_limpeza, s_erro, zona_ativa, fim_zona};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs cycle=%0d got=%b required=%b", mon_idx, act_v, exp_v);
                end
                if (fim_zona === 1'b1) begin
                    checks++;
                    if (fim_cyc_q.size() == 0) begin
                        errors++;
                        $display("FAIL fim_zona cycle=%0d got=pulse required=none", mon_idx);
                    end else begin
                        c = fim_cyc_q.pop_front();
                        if (c != mon_idx) begin
                            errors++;
                            $display("FAIL fim_zona_cycle got=%0d required=%0d", mon_idx, c);
                        end
                    end
                end
                mon_idx++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cycle);
        $fatal(1);
    end

    initial begin
        int lvl;
        rst = 1; req = '0; modo = '0; agro = 0; e = 0;
        set_level(0);

        // 1: reset, then sensors rise one by one
        repeat (3) tick();
        rst = 0;
        repeat (3) tick();
        l = 1; tick();
        m = 1; tick();
        h = 1; tick();
        tick();

        // 2: zone0 sprinkler, then zone2 drip
        req = 4'b0101; modo = 4'b0001; tick();
        req = '0;
        repeat (70) tick();

        // 3: zone1 aborted by L drop, refill, restart; third completion -> LIMPEZA
        req = 4'b0010; modo = 4'b0000; tick();
        req = '0;
        repeat (6) tick();
        set_level(0);
        repeat (4) tick();
        set_level(3);
        repeat (60) tick();

        // 5: error during irrigation, then sensor fault, then recovery
        req = 4'b1000; modo = 4'b1000; agro = 1; tick();
        req = '0;
        repeat (6) tick();
        e = 1; tick();
        e = 0; repeat (3) tick();
        m = 0; repeat (2) tick();
        m = 1; repeat (30) tick();

        // 6: fill timeout
        set_level(0);
        repeat (105) tick();
        set_level(3);
        repeat (5) tick();

        // Randomized operation
        lvl = 3;
        for (int i = 0; i < 1800; i++) begin
            if ($urandom_range(39) == 0)
                lvl = ($urandom_range(2) == 0) ? int'($urandom_range(2)) : 3;
            set_level(lvl);
            if ($urandom_range(149) == 0) begin h = 1; m = 0; end
            e    = ($urandom_range(249) == 0);
            rst  = ($urandom_range(599) == 0);
            req  = ($urandom_range(7) == 0) ? N'($urandom) : '0;
            if ($urandom_range(15) == 0) modo = N'($urandom);
            agro = $urandom_range(1) == 1;
            tick();
        end

        rst = 0; e = 0; req = '0; set_level(3);
        repeat (2) tick();
        @(negedge clk);
        #1;
        checks++;
        if (fim_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL fim_zona_missing got=%0d pulses outstanding required=0", fim_cyc_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
